// File: rtl/free_list.sv
// Free-list manager for fixed-size memory blocks.
// A circular FIFO holds every block index that is currently free. After reset
// the pool fills itself with 0..NUM_BLOCKS-1, one entry per cycle. It then
// hands out indices with zero latency and takes them back in FIFO order.
module free_list #(
    parameter int ADDR_W     = 10,
    parameter int NUM_BLOCKS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [ADDR_W-1:0] alloc_block_idx_o,
    input  logic              free_req_i,
    input  logic [ADDR_W-1:0] free_block_idx_i,
    output logic              init_done_o,
    output logic [ADDR_W:0]   free_count_o,
    output logic              empty_o,
    output logic              overflow_err_o
);

    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(NUM_BLOCKS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_BLOCKS - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W:0]   count;
    logic              overflow;

    logic [ADDR_W-1:0] entries [NUM_BLOCKS];

    logic              alloc_gnt;
    logic              free_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] head_idx;

    // Grant, free acceptance and the single storage write port.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        alloc_gnt   = 1'b0;
        free_accept = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        head_idx    = '0;
        if (state == READY) begin
            // A grant needs an index that is already stored. A free in the
            // same cycle is never passed straight through to the allocator.
            alloc_gnt   = alloc_req_i && (count != '0);
            free_accept = free_req_i && (count != FULL_COUNT);
            mem_we      = free_accept;
            mem_wdata   = free_block_idx_i;
            head_idx    = entries[rd_ptr];
        end else begin
            mem_we    = 1'b1;
            mem_wdata = init_cnt;
        end
    end

    // Storage array: one write per cycle at wr_ptr.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; INIT rewrites every entry before any entry can be read.
        if (mem_we) begin
            entries[wr_ptr] <= mem_wdata;
        end
    end

    // FSM, pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register here sees the values from before the edge.
        if (!rst_n) begin
            state    <= INIT;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            init_cnt <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (free_req_i && !free_accept) begin
                overflow <= 1'b1;
            end
            if (state == INIT) begin
                wr_ptr   <= wr_ptr + 1'b1;
                count    <= count + 1'b1;
                init_cnt <= init_cnt + 1'b1;
                // wr_ptr wraps back to 0 on the last write, so READY starts
                // with both pointers at 0.
                if (init_cnt == LAST_IDX) begin
                    state <= READY;
                end
            end else begin
                if (alloc_gnt) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (free_accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                case ({free_accept, alloc_gnt})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign alloc_gnt_o       = alloc_gnt;
    assign alloc_block_idx_o = head_idx;
    assign init_done_o       = (state == READY);
    assign free_count_o      = count;
    assign empty_o           = (count == '0);
    assign overflow_err_o    = overflow;

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list with ADDR_W=4 (16 blocks).
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling
// edge of the same cycle, before the next rising edge commits the cycle.
module tb_free_list;

    localparam int ADDR_W = 4;
    localparam int NB     = 16;

    logic              clk;
    logic              rst_n;
    logic              alloc_req;
    logic              alloc_gnt;
    logic [ADDR_W-1:0] alloc_idx;
    logic              free_req;
    logic [ADDR_W-1:0] free_idx;
    logic              init_done;
    logic [ADDR_W:0]   free_count;
    logic              empty;
    logic              overflow_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       alloc;
        logic       free;
        logic [3:0] fidx;
        logic       exp_gnt;
        logic [3:0] exp_idx;
        logic [4:0] exp_count;
        logic       exp_empty;
    } vec_t;

    vec_t vecs [13];

    free_list #(
        .ADDR_W     (ADDR_W),
        .NUM_BLOCKS (NB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_req_i       (alloc_req),
        .alloc_gnt_o       (alloc_gnt),
        .alloc_block_idx_o (alloc_idx),
        .free_req_i        (free_req),
        .free_block_idx_i  (free_idx),
        .init_done_o       (init_done),
        .free_count_o      (free_count),
        .empty_o           (empty),
        .overflow_err_o    (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(alloc_gnt), 32'd0);
        check({tag, "_idx"},   32'(alloc_idx), 32'd0);
        check({tag, "_done"},  32'(init_done), 32'd0);
        check({tag, "_count"}, 32'(free_count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_ovf"},   32'(overflow_err), 32'd0);
    endtask

    initial begin
        // Starts from empty with rd_ptr = wr_ptr = 0 after the first full drain.
        // Covers: no bypass, free 5/9 then alloc twice, then alloc and free
        // in the same cycle at count 3.
        //          alloc free  fidx   gnt   idx    count  empty
        vecs[0]  = '{1'b1, 1'b1, 4'd5,  1'b0, 4'd0,  5'd0,  1'b1};
        vecs[1]  = '{1'b0, 1'b1, 4'd9,  1'b0, 4'd0,  5'd1,  1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd5,  5'd2,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd9,  5'd1,  1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  5'd0,  1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'd11, 1'b0, 4'd0,  5'd0,  1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'd12, 1'b0, 4'd0,  5'd1,  1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'd13, 1'b0, 4'd0,  5'd2,  1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'd7,  1'b1, 4'd11, 5'd3,  1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd12, 5'd3,  1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd13, 5'd2,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd7,  5'd1,  1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  5'd0,  1'b1};

        rst_n     = 1'b0;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        free_idx  = '0;

        // Reset held for several edges.
        next_cycle();
        next_cycle();
        sample();
        check_reset_outputs("rst_hold");
        next_cycle();

        // First INIT with an allocation request held from release.
        rst_n     = 1'b1;
        alloc_req = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            sample();
            check($sformatf("init1_gnt_c%0d", k),   32'(alloc_gnt), 32'd0);
            check($sformatf("init1_done_c%0d", k),  32'(init_done), 32'd0);
            check($sformatf("init1_idx_c%0d", k),   32'(alloc_idx), 32'd0);
            check($sformatf("init1_count_c%0d", k), 32'(free_count), 32'(k - 1));
            next_cycle();
        end

        // Cycle 17 onwards: ready, full, and indices 0..15 granted in order.
        for (int k = 0; k < NB; k++) begin
            sample();
            check($sformatf("drain_done_%0d", k),  32'(init_done), 32'd1);
            check($sformatf("drain_gnt_%0d", k),   32'(alloc_gnt), 32'd1);
            check($sformatf("drain_idx_%0d", k),   32'(alloc_idx), 32'(k));
            check($sformatf("drain_count_%0d", k), 32'(free_count), 32'(NB - k));
            next_cycle();
        end
        sample();
        check("drained_gnt",   32'(alloc_gnt), 32'd0);
        check("drained_empty", 32'(empty), 32'd1);
        check("drained_count", 32'(free_count), 32'd0);
        alloc_req = 1'b0;
        next_cycle();

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            alloc_req = vecs[i].alloc;
            free_req  = vecs[i].free;
            free_idx  = vecs[i].fidx;
            sample();
            check($sformatf("vec%0d_gnt", i),   32'(alloc_gnt), 32'(vecs[i].exp_gnt));
            if (vecs[i].exp_gnt) begin
                check($sformatf("vec%0d_idx", i), 32'(alloc_idx), 32'(vecs[i].exp_idx));
            end
            check($sformatf("vec%0d_count", i), 32'(free_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_ovf", i),   32'(overflow_err), 32'd0);
            next_cycle();
        end
        alloc_req = 1'b0;
        free_req  = 1'b0;

        // Refill to full with indices 0..15.
        for (int i = 0; i < NB; i++) begin
            free_req = 1'b1;
            free_idx = 4'(i);
            sample();
            check($sformatf("fill_count_%0d", i), 32'(free_count), 32'(i));
            next_cycle();
        end

        // Free into a full pool: dropped, sticky overflow, count unchanged.
        free_idx = 4'd2;
        sample();
        check("full_count_pre", 32'(free_count), 32'd16);
        check("full_ovf_pre",   32'(overflow_err), 32'd0);
        next_cycle();
        free_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check($sformatf("full_ovf_post_%0d", k),   32'(overflow_err), 32'd1);
            check($sformatf("full_count_post_%0d", k), 32'(free_count), 32'd16);
            next_cycle();
        end

        // Allocate 8: the dropped free must not have overwritten the head.
        alloc_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            check($sformatf("half_gnt_%0d", i), 32'(alloc_gnt), 32'd1);
            check($sformatf("half_idx_%0d", i), 32'(alloc_idx), 32'(i));
            next_cycle();
        end
        alloc_req = 1'b0;
        sample();
        check("mid_count", 32'(free_count), 32'd8);

        // One-cycle reset in the middle of traffic.
        rst_n = 1'b0;
        next_cycle();
        rst_n     = 1'b1;
        alloc_req = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            free_req = (k == 5);
            free_idx = 4'd9;
            sample();
            if (k == 1) begin
                check_reset_outputs("rst_mid");
            end
            check($sformatf("init2_gnt_c%0d", k),   32'(alloc_gnt), 32'd0);
            check($sformatf("init2_done_c%0d", k),  32'(init_done), 32'd0);
            check($sformatf("init2_count_c%0d", k), 32'(free_count), 32'(k - 1));
            check($sformatf("init2_ovf_c%0d", k),   32'(overflow_err), 32'(k >= 6));
            next_cycle();
        end
        free_req = 1'b0;

        for (int k = 0; k < NB; k++) begin
            sample();
            check($sformatf("redrain_gnt_%0d", k), 32'(alloc_gnt), 32'd1);
            check($sformatf("redrain_idx_%0d", k), 32'(alloc_idx), 32'(k));
            next_cycle();
        end
        sample();
        check("redrain_gnt_end",   32'(alloc_gnt), 32'd0);
        check("redrain_empty_end", 32'(empty), 32'd1);
        check("redrain_ovf_end",   32'(overflow_err), 32'd1);
        alloc_req = 1'b0;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
